// File: rtl/chip8_pkg.sv
// chip8_pkg: shared geometry constants and draw FSM state encoding for the CHIP-8 sprite datapath.
package chip8_pkg;
  localparam int CHIP8_ROWS = 32;
  localparam int CHIP8_COLS = 64;
  localparam int CHIP8_ADDR_W = 12;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, RD, WR, DONE} draw_state_t;
endpackage

// File: rtl/chip8_sprite_mask.sv
// chip8_sprite_mask: places a sprite byte (MSB = leftmost) at column x0 of a row word.
// CHIP8_DRAW_WRAP_EN folds columns past the right edge back to column 0; otherwise they are clipped.
module chip8_sprite_mask
  import chip8_pkg::*;
#(
  parameter int COLS = CHIP8_COLS
) (
  input  logic [7:0]              sprite_byte_in,
  input  logic [$clog2(COLS)-1:0] x0_in,
  output logic [COLS-1:0]         mask_out
);
  logic [7:0] rev;
  assign rev = {<<{sprite_byte_in}};
`ifdef CHIP8_DRAW_WRAP_EN
  logic [COLS+7:0] wide;
  assign wide = {{COLS{1'b0}}, rev} << x0_in;
  assign mask_out = wide[COLS-1:0] | {{(COLS-8){1'b0}}, wide[COLS+7:COLS]};
`else
  assign mask_out = {{(COLS-8){1'b0}}, rev} << x0_in;
`endif
endmodule

// File: rtl/chip8_draw_ctrl.sv
// chip8_draw_ctrl: CHIP-8 DXYN/00E0 sequencer doing XOR read-modify-write on framebuffer rows.
// Build with CHIP8_DRAW_WRAP_EN to wrap sprites around the screen edges instead of clipping.
module chip8_draw_ctrl
  import chip8_pkg::*;
#(
  parameter int ADDR_W = CHIP8_ADDR_W,
  parameter int ROWS = CHIP8_ROWS,
  parameter int COLS = CHIP8_COLS
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    draw_start_in,
  input  logic                    clear_start_in,
  input  logic [ADDR_W-1:0]       sprite_addr_in,
  input  logic [7:0]              sprite_x_in,
  input  logic [7:0]              sprite_y_in,
  input  logic [3:0]              sprite_n_in,
  output logic                    mem_req_out,
  output logic [ADDR_W-1:0]       mem_addr_out,
  input  logic                    mem_valid_in,
  input  logic [7:0]              mem_data_in,
  output logic [$clog2(ROWS)-1:0] fb_addr_out,
  output logic                    fb_rd_out,
  input  logic [COLS-1:0]         fb_rd_data_in,
  output logic                    fb_we_out,
  output logic [COLS-1:0]         fb_wr_data_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    collision_out
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = RW + 5;
  draw_state_t state_q;
  logic [CW-1:0] x0_q;
  logic [RW-1:0] y0_q, cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0] n_q, r_q;
  logic [7:0] byte_q;
  logic acc_q, vf_q;
  logic [SW-1:0] row_sum;
  logic [COLS-1:0] mask;
  logic hit, last;

  chip8_sprite_mask #(.COLS(COLS)) u_mask (
    .sprite_byte_in(byte_q),
    .x0_in(x0_q),
    .mask_out(mask)
  );

  assign row_sum = SW'(y0_q) + SW'(r_q);
  assign hit = |(fb_rd_data_in & mask);
`ifdef CHIP8_DRAW_WRAP_EN
  assign last = 5'(r_q) + 5'd1 == 5'(n_q);
`else
  // stop before the first row that would fall off the bottom of the screen
  assign last = (5'(r_q) + 5'd1 == 5'(n_q)) || (row_sum + SW'(1) >= SW'(ROWS));
`endif

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      cnt_q <= '0;
      base_q <= '0;
      n_q <= '0;
      r_q <= '0;
      byte_q <= '0;
      acc_q <= 1'b0;
      vf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (clear_start_in) begin
            state_q <= CLEAR;
            cnt_q <= '0;
            acc_q <= 1'b0;
            vf_q <= 1'b0;
          end else if (draw_start_in) begin
            state_q <= sprite_n_in == 4'd0 ? DONE : FETCH;
            x0_q <= CW'(sprite_x_in);
            y0_q <= RW'(sprite_y_in);
            base_q <= sprite_addr_in;
            n_q <= sprite_n_in;
            r_q <= '0;
            acc_q <= 1'b0;
            vf_q <= 1'b0;
          end
        CLEAR: begin
          cnt_q <= cnt_q + RW'(1);
          if (cnt_q == RW'(ROWS - 1)) state_q <= DONE;
        end
        FETCH: state_q <= WAIT;
        WAIT:
          if (mem_valid_in) begin
            byte_q <= mem_data_in;
            state_q <= RD;
          end
        RD: state_q <= WR;
        WR: begin
          acc_q <= acc_q | hit;
          if (last) vf_q <= acc_q | hit;
          r_q <= r_q + 4'd1;
          state_q <= last ? DONE : FETCH;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end

  assign mem_req_out = state_q == FETCH;
  assign mem_addr_out = mem_req_out ? base_q + ADDR_W'(r_q) : '0;
  assign fb_rd_out = state_q == RD;
  assign fb_we_out = state_q == WR || state_q == CLEAR;
  assign fb_addr_out = state_q == CLEAR ? cnt_q : (fb_rd_out || state_q == WR) ? row_sum[RW-1:0] : '0;
  assign fb_wr_data_out = state_q == WR ? fb_rd_data_in ^ mask : '0;
  assign busy_out = state_q != IDLE && state_q != DONE;
  assign done_out = state_q == DONE;
  assign collision_out = vf_q;
endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// tb_chip8_draw_ctrl: scoreboard bench for the CHIP-8 draw/clear sequencer.
// Expected rows follow CHIP8_DRAW_WRAP_EN when the bench is built with it.
module tb_chip8_draw_ctrl;
  localparam int AW = 12;
  localparam int ROWS = 32;
  localparam int COLS = 64;
  typedef struct packed {logic [4:0] a; logic [COLS-1:0] d;} wr_t;
  typedef struct packed {int lat; logic coll;} dn_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic draw_start = 1'b0, clear_start = 1'b0;
  logic [AW-1:0] sprite_addr = '0;
  logic [7:0] sprite_x = '0, sprite_y = '0;
  logic [3:0] sprite_n = '0;
  logic mem_req, mem_valid = 1'b0;
  logic [AW-1:0] mem_addr, maddr = '0;
  logic [7:0] mem_data = '0;
  logic [4:0] fb_addr;
  logic fb_rd, fb_we, busy, done, coll;
  logic [COLS-1:0] fb_rd_data = '0, fb_wr_data;
  logic [COLS-1:0] fb [ROWS];
  logic [7:0] smem [1<<AW];
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  wr_t ew_q;
  dn_t ed_q;
  int cyc = 0, start_cyc = 0, vecs = 0, errs = 0, nreq = 0, mem_delay = 1, mcnt = 0;

  always #5 clk = ~clk;

  chip8_draw_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .draw_start_in(draw_start), .clear_start_in(clear_start),
    .sprite_addr_in(sprite_addr), .sprite_x_in(sprite_x), .sprite_y_in(sprite_y), .sprite_n_in(sprite_n),
    .mem_req_out(mem_req), .mem_addr_out(mem_addr), .mem_valid_in(mem_valid), .mem_data_in(mem_data),
    .fb_addr_out(fb_addr), .fb_rd_out(fb_rd), .fb_rd_data_in(fb_rd_data),
    .fb_we_out(fb_we), .fb_wr_data_out(fb_wr_data),
    .busy_out(busy), .done_out(done), .collision_out(coll)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (fb_rd) fb_rd_data <= fb[fb_addr];
    if (fb_we) fb[fb_addr] <= fb_wr_data;
  end

  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mcnt == 1) begin
      mem_valid <= 1'b1;
      mem_data <= smem[maddr];
    end
    if (mcnt > 0) mcnt <= mcnt - 1;
    if (mem_req) begin
      if (mem_delay == 1) begin
        mem_valid <= 1'b1;
        mem_data <= smem[mem_addr];
      end else begin
        maddr <= mem_addr;
        mcnt <= mem_delay - 1;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (mem_req) nreq++;
    if (fb_we) begin
      vecs++;
      if (exp_wr.size() == 0) begin
        errs++;
        $display("FAIL wr_extra: row %0d data %h written, none expected", fb_addr, fb_wr_data);
      end else begin
        ew_q = exp_wr.pop_front();
        if (fb_addr !== ew_q.a || fb_wr_data !== ew_q.d) begin
          errs++;
          $display("FAIL wr: row %0d data %h, expected row %0d data %h", fb_addr, fb_wr_data, ew_q.a, ew_q.d);
        end
      end
    end
    if (done) begin
      vecs++;
      if (exp_dn.size() == 0) begin
        errs++;
        $display("FAIL done_extra: done_out at cycle %0d, none expected", cyc - start_cyc);
      end else begin
        ed_q = exp_dn.pop_front();
        if (cyc - start_cyc != ed_q.lat || coll !== ed_q.coll || busy !== 1'b0) begin
          errs++;
          $display("FAIL done: lat %0d coll %b busy %b, expected lat %0d coll %b busy 0",
                   cyc - start_cyc, coll, busy, ed_q.lat, ed_q.coll);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic ew(input int r, input logic [COLS-1:0] d);
    exp_wr.push_back({5'(r), d});
  endtask

  task automatic ed(input int lat, input logic c);
    exp_dn.push_back({lat, c});
  endtask

  task automatic op(input logic dr, input logic cl, input logic [7:0] x, input logic [7:0] y,
                    input logic [3:0] n, input logic [AW-1:0] a);
    @(posedge clk); #1;
    sprite_x = x; sprite_y = y; sprite_n = n; sprite_addr = a;
    draw_start = dr; clear_start = cl;
    start_cyc = cyc;
    @(posedge clk); #1;
    draw_start = 1'b0; clear_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < lim);
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: no done_out within %0d cycles", lim);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, 128'({mem_req, mem_addr, fb_addr, fb_rd, fb_we, busy, done, coll}), 128'(0));
    chk({name, "_wdata"}, 128'(fb_wr_data), 128'(0));
  endtask

  initial begin
    int n0, k;
    for (int i = 0; i < ROWS; i++) fb[i] = {32'hDEADBEEF, 32'(i)};
    for (int i = 0; i < (1 << AW); i++) smem[i] = 8'h00;
    smem[12'h200] = 8'hF0;
    smem[12'h300] = 8'hFF; smem[12'h301] = 8'hFF;
    smem[12'h400] = 8'hC0; smem[12'h401] = 8'h0A; smem[12'h402] = 8'h24; smem[12'h403] = 8'h18;
    #3 chk_zero("reset_outs");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < ROWS; i++) ew(i, '0);
    ed(33, 1'b0);
    op(1'b0, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000);
    wait_done(40);

    ew(3, 64'h3C); ed(5, 1'b0);
    op(1'b1, 1'b0, 8'd2, 8'd3, 4'd1, 12'h200);
    wait_done(10);
    ew(3, 64'h0); ed(5, 1'b1);
    op(1'b1, 1'b0, 8'd2, 8'd3, 4'd1, 12'h200);
    wait_done(10);
    repeat (3) @(posedge clk);
    #1 chk("vf_hold", 128'(coll), 128'(1));

    ed(1, 1'b0);
    op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h200);
    wait_done(5);

    ew(8, 64'hF00); ed(5, 1'b0);
    op(1'b1, 1'b0, 8'd200, 8'd40, 4'd1, 12'h200);
    wait_done(10);

`ifdef CHIP8_DRAW_WRAP_EN
    ew(31, 64'hC000_0000_0000_003F); ew(0, 64'hC000_0000_0000_003F); ed(9, 1'b0);
`else
    ew(31, 64'hC000_0000_0000_0000); ed(5, 1'b0);
`endif
    op(1'b1, 1'b0, 8'd62, 8'd31, 4'd2, 12'h300);
    wait_done(15);

    mem_delay = 5;
    ew(10, 64'h3); ew(11, 64'h50); ed(17, 1'b0);
    op(1'b1, 1'b0, 8'd0, 8'd10, 4'd2, 12'h400);
    repeat (2) @(posedge clk);
    #1 chk("stall_outs", 128'({busy, mem_req, fb_we, fb_rd}), 128'(4'b1000));
    sprite_x = 8'd5; sprite_y = 8'd5; sprite_n = 4'd3; draw_start = 1'b1;
    @(posedge clk); #1 draw_start = 1'b0; clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    wait_done(30);
    mem_delay = 1;
    repeat (10) @(posedge clk);

    ew(20, 64'h3);
    n0 = nreq;
    op(1'b1, 1'b0, 8'd0, 8'd20, 4'd4, 12'h400);
    k = 0;
    while (nreq < n0 + 2 && k < 20) begin @(negedge clk); k++; end
    chk("row1_fetch", 128'(nreq >= n0 + 2), 128'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst_outs");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);

    n0 = nreq;
    for (int i = 0; i < ROWS; i++) ew(i, '0);
    ed(33, 1'b0);
    op(1'b1, 1'b1, 8'd2, 8'd3, 4'd1, 12'h200);
    wait_done(40);
    repeat (3) @(posedge clk);
    #1 chk("no_fetch", 128'(nreq), 128'(n0));

    chk("wr_left", 128'(exp_wr.size()), 128'(0));
    chk("done_left", 128'(exp_dn.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
